mont_mul_array: RTL and testbench

- LANES-wide pipelined Montgomery modular multiplier for the NTT butterfly and pointwise-multiply datapaths.
- Computes r = a*b*R^-1 mod Q per lane, where R = 2^DATA_WIDTH.
- Adds three things over the single-lane multiplier:
  - valid/ready backpressure;
  - a tag carried alongside the data;
  - an optional canonical-output stage and a sticky input-range error flag.

---
 rtl/ntt_pkg.sv | 44 ++++
 rtl/mont_mul_array_if.sv | 28 ++
 rtl/mont_red_lane.sv | 77 +++++++
 rtl/mont_mul_array.sv | 78 +++++++
 tb/tb_mont_mul_array.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and Montgomery helpers (Kyber field).
package ntt_pkg;

    localparam int DATA_WIDTH    = 12;
    localparam int Q             = 3329;
    localparam int MUL_STAGE_CNT = 3;

    typedef logic [DATA_WIDTH-1:0]   coef_t;
    typedef logic [2*DATA_WIDTH-1:0] prod_t;
    typedef logic [2*DATA_WIDTH:0]   sum_t;
    typedef logic [DATA_WIDTH:0]     lazy_t;

    localparam coef_t Q_C = coef_t'(Q);

    // Newton iteration for Q^-1 mod 2^DATA_WIDTH; an odd Q is its own
    // inverse mod 8, and each step doubles the number of correct bits.
    function automatic coef_t calc_qinv_neg();
        coef_t x;
        x = Q_C;
        for (int i = 0; i < 6; i++) begin
            x = x * (coef_t'(2) - Q_C * x);
        end
        return -x;
    endfunction

    localparam coef_t QINV_NEG = calc_qinv_neg();
    localparam int    R_MOD_Q  = (1 << DATA_WIDTH) % Q;
    localparam int    R2_MOD_Q = (R_MOD_Q * R_MOD_Q) % Q;

    // m = (t mod R) * (-Q^-1) mod R; truncation to coef_t is the mod R.
    function automatic coef_t mont_m(input prod_t t);
        coef_t m;
        m = t[DATA_WIDTH-1:0] * QINV_NEG;
        return m;
    endfunction

    // u = (t + m*Q) / R; low DATA_WIDTH bits of the sum are zero by construction.
    function automatic lazy_t mont_u(input prod_t t, input coef_t m);
        sum_t s;
        s = sum_t'(t) + sum_t'(m) * sum_t'(Q);
        return s[2*DATA_WIDTH:DATA_WIDTH];
    endfunction

endpackage

// File: rtl/mont_mul_array_if.sv
// Beat-level valid/ready bus of the Montgomery multiplier array.
interface mont_mul_array_if
    import ntt_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) ();
    logic                           in_valid;
    logic                           in_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0] in_a;
    logic [LANES-1:0][DATA_WIDTH-1:0] in_b;
    logic [TAG_W-1:0]               in_tag;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES-1:0][DATA_WIDTH:0] out_r;
    logic [TAG_W-1:0]               out_tag;
    logic                           range_err;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag, range_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag, range_err
    );
endinterface

// File: rtl/mont_red_lane.sv
// One Montgomery multiply lane: a*b*R^-1, lazy or canonical output.
module mont_red_lane
    import ntt_pkg::*;
#(
    parameter int STAGES    = MUL_STAGE_CNT,
    parameter bit CANONICAL = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  coef_t a,
    input  coef_t b,
    output lazy_t r
);
    // Reduction result lands at stage 2 (single-cycle m*Q+add) or stage 3
    // (m registered separately); any remaining stages are plain delay.
    localparam int RED_STG = (STAGES == 2) ? 2 : 3;
    localparam int DLY     = STAGES - RED_STG;

    prod_t t_q;
    lazy_t u_d;
    lazy_t u_pipe [0:DLY];
    lazy_t u_fin;

    // Stage 1: full-width product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     t_q <= '0;
        else if (en) t_q <= prod_t'(a) * prod_t'(b);
    end

    if (STAGES == 2) begin : g_red2
        assign u_d = mont_u(t_q, mont_m(t_q));
    end else begin : g_red3
        prod_t t2_q;
        coef_t m2_q;

        // Stage 2: quotient digit m alongside the product.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                t2_q <= '0;
                m2_q <= '0;
            end else if (en) begin
                t2_q <= t_q;
                m2_q <= mont_m(t_q);
            end
        end

        assign u_d = mont_u(t2_q, m2_q);
    end

    // Reduced value plus trailing delay stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DLY; i++) u_pipe[i] <= '0;
        end else if (en) begin
            u_pipe[0] <= u_d;
            for (int i = 1; i <= DLY; i++) u_pipe[i] <= u_pipe[i-1];
        end
    end

    assign u_fin = u_pipe[DLY];

    if (CANONICAL) begin : g_canon
        lazy_t r_q;

        // Final stage folds [0,2Q) into [0,Q).
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     r_q <= '0;
            else if (en) r_q <= (u_fin >= lazy_t'(Q)) ? u_fin - lazy_t'(Q) : u_fin;
        end

        assign r = r_q;
    end else begin : g_lazy
        assign r = u_fin;
    end

endmodule

// File: rtl/mont_mul_array.sv
// LANES-wide pipelined Montgomery multiplier with valid/ready, tag and range flag.
module mont_mul_array
    import ntt_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int STAGES    = MUL_STAGE_CNT,
    parameter bit CANONICAL = 1'b1,
    parameter int TAG_W     = 4
) (
    input logic             clk,
    input logic             rst,
    mont_mul_array_if.slave bus
);
    localparam int L = STAGES + (CANONICAL ? 1 : 0);

    logic                           en;
    logic                           acc;
    logic                           oob;
    logic                           range_err_q;
    logic [L:1]                     vld_pipe;
    logic [TAG_W-1:0]               tag_pipe [1:L];
    logic [LANES-1:0][DATA_WIDTH:0] lane_r;

    // Whole pipeline moves as one; the output slot frees when taken or empty.
    assign en  = !vld_pipe[L] || bus.out_ready;
    assign acc = bus.in_valid && en;

    // Any lane operand outside [0,Q) on the beat being presented.
    always_comb begin
        oob = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_a[i] >= Q_C || bus.in_b[i] >= Q_C) oob = 1'b1;
        end
    end

    // Valid shift register; bubbles advance like real beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[L-1:1], acc};
    end

    // Tag rides alongside its beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= L; i++) tag_pipe[i] <= '0;
        end else if (en) begin
            tag_pipe[1] <= bus.in_tag;
            for (int i = 2; i <= L; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Sticky out-of-range flag, only for beats actually accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             range_err_q <= 1'b0;
        else if (acc && oob) range_err_q <= 1'b1;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mont_red_lane #(
            .STAGES   (STAGES),
            .CANONICAL(CANONICAL)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .en (en),
            .a  (bus.in_a[i]),
            .b  (bus.in_b[i]),
            .r  (lane_r[i])
        );
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[L];
    assign bus.out_r     = lane_r;
    assign bus.out_tag   = tag_pipe[L];
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_mont_mul_array.sv
// Directed bench for mont_mul_array (Kyber Q=3329, 4 lanes, canonical output).
module tb_mont_mul_array;
    import ntt_pkg::*;

    localparam int     LANES  = 4;
    localparam int     TAG_W  = 4;
    localparam int     STAGES = MUL_STAGE_CNT;
    localparam int     L      = STAGES + 1;
    localparam longint RINV   = 2704;   // 4096^-1 mod 3329, by extended Euclid

    typedef logic [LANES-1:0][DATA_WIDTH:0] res_t;
    typedef struct {
        res_t             r;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    mont_mul_array_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    mont_mul_array #(
        .LANES(LANES), .STAGES(STAGES), .CANONICAL(1'b1), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_a(input int i, input int k);
        return (i * 113 + k * 997 + 3328) % 3329;
    endfunction

    function automatic int op_b(input int i, input int k);
        return (i * 2897 + k * 1231) % 3329;
    endfunction

    // Golden: a*b*R^-1 mod Q by plain modular arithmetic.
    function automatic exp_t model(input int i);
        exp_t   e;
        longint p;
        for (int k = 0; k < LANES; k++) begin
            p = (longint'(op_a(i, k)) * longint'(op_b(i, k))) % 3329;
            p = (p * RINV) % 3329;
            e.r[k] = (DATA_WIDTH+1)'(p);
        end
        e.tag = TAG_W'(i);
        return e;
    endfunction

    task automatic present(input int i);
        bus.in_valid = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            bus.in_a[k] = coef_t'(op_a(i, k));
            bus.in_b[k] = coef_t'(op_b(i, k));
        end
        bus.in_tag = TAG_W'(i);
    endtask

    // Streams beats 0..n-1, scoreboards results, checks stability during stalls.
    task automatic stream(input int n, input bit bp, input string nm, output int cyc);
        exp_t             q[$];
        exp_t             e;
        int               sent = 0;
        int               got  = 0;
        bit               stall = 1'b0;
        res_t             hr;
        logic [TAG_W-1:0] ht;
        cyc = 0;
        while (got < n && cyc < 20 * n + 50) begin
            if (sent < n) present(sent);
            else          bus.in_valid = 1'b0;
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stall) begin
                chk({nm, "_hold_v"}, 64'(bus.out_valid), 64'd1);
                chk({nm, "_hold_r"}, 64'(bus.out_r), 64'(hr));
                chk({nm, "_hold_tag"}, 64'(bus.out_tag), 64'(ht));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk({nm, "_nonempty"}, 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk({nm, "_r"}, 64'(bus.out_r), 64'(e.r));
                    chk({nm, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
                    for (int k = 0; k < LANES; k++)
                        chk({nm, "_canon"}, 64'(bus.out_r[k] < 3329), 64'd1);
                end
                got++;
            end
            stall = bus.out_valid && !bus.out_ready;
            hr    = bus.out_r;
            ht    = bus.out_tag;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(sent));
                sent++;
            end
            tick();
            cyc++;
        end
        chk({nm, "_count"}, 64'(got), 64'(n));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   cyc;
        int   nacc;
        int   bl[LANES] = '{5, 3328, 0, 1};
        res_t er;
        exp_t e;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_r", 64'(bus.out_r), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_err", 64'(bus.range_err), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 64'(bus.in_ready), 64'd1);

        // Identity: a = R mod Q makes the result equal b
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 4'd9;
        for (int k = 0; k < LANES; k++) begin
            bus.in_a[k] = 12'd767;
            bus.in_b[k] = coef_t'(bl[k]);
            er[k]       = (DATA_WIDTH+1)'(bl[k]);
        end
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            chk("id_valid", 64'(bus.out_valid), 64'(k == L));
            if (k == L) begin
                chk("id_r", 64'(bus.out_r), 64'(er));
                chk("id_tag", 64'(bus.out_tag), 64'd9);
            end
            tick();
        end

        // Hand values: R^2 mod Q times 1 -> R mod Q; (Q-1)^2 -> R^-1
        bus.in_valid = 1'b1;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_a[0]  = 12'd2385;  bus.in_b[0] = 12'd1;
        bus.in_a[1]  = 12'd3328;  bus.in_b[1] = 12'd3328;
        bus.in_tag   = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (L - 1) tick();
        chk("hand_valid", 64'(bus.out_valid), 64'd1);
        chk("hand_r2", 64'(bus.out_r[0]), 64'd767);
        chk("hand_m1sq", 64'(bus.out_r[1]), 64'd2704);
        chk("hand_zero", 64'(bus.out_r[2]), 64'd0);
        tick();

        // Sweep at full rate, boundaries 0 and 3328 included
        stream(200, 1'b0, "sweep", cyc);
        chk("sweep_cycles", 64'(cyc), 64'(200 + L));

        // Random backpressure, tags 0..15 in order
        stream(16, 1'b1, "bp", cyc);

        // Fill with output blocked: exactly L beats go in
        bus.out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < L + 3; c++) begin
            present(nacc);
            @(negedge clk);
            if (bus.in_ready) nacc++;
            tick();
        end
        chk("fill_count", 64'(nacc), 64'(L));
        @(negedge clk);
        chk("fill_ready", 64'(bus.in_ready), 64'd0);
        tick();
        // Full pipe with output open: one in, one out every cycle
        bus.out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            present(L + j);
            e = model(j);
            @(negedge clk);
            chk("tp_ready", 64'(bus.in_ready), 64'd1);
            chk("tp_valid", 64'(bus.out_valid), 64'd1);
            chk("tp_r", 64'(bus.out_r), 64'(e.r));
            chk("tp_tag", 64'(bus.out_tag), 64'(e.tag));
            tick();
        end
        bus.in_valid = 1'b0;
        for (int j = 8; j < 8 + L; j++) begin
            e = model(j);
            @(negedge clk);
            chk("drain_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_r", 64'(bus.out_r), 64'(e.r));
            tick();
        end
        @(negedge clk);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);
        tick();

        // Range error: illegal beat ignored while in_ready=0
        chk("rerr_clear", 64'(bus.range_err), 64'd0);
        bus.out_ready = 1'b0;
        for (int c = 0; c < L; c++) begin
            present(100 + c);
            tick();
        end
        present(200);
        bus.in_a[2] = 12'd3329;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rerr_blk_ready", 64'(bus.in_ready), 64'd0);
            tick();
            chk("rerr_blocked", 64'(bus.range_err), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (L + 1) tick();
        // Accepted illegal beat sets the flag the next cycle
        present(201);
        bus.in_a[2] = 12'd3329;
        @(negedge clk);
        chk("rerr_pre", 64'(bus.range_err), 64'd0);
        tick();
        chk("rerr_set", 64'(bus.range_err), 64'd1);
        for (int c = 0; c < 3; c++) begin
            present(202 + c);
            tick();
            chk("rerr_sticky", 64'(bus.range_err), 64'd1);
        end
        bus.in_valid = 1'b0;
        repeat (L + 2) tick();

        // Reset with three beats in flight
        for (int c = 0; c < 3; c++) begin
            present(300 + c);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_r_nz", 64'(bus.out_r != '0), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_r", 64'(bus.out_r), 64'd0);
        chk("arst_tag", 64'(bus.out_tag), 64'd0);
        chk("arst_err", 64'(bus.range_err), 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < L + 3; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
